rotate_monitor: RTL and testbench

- Receiving end of the 8-bit one-hot rotating LED pattern that the rotate stage drives.
- Samples the pattern on a sample strobe and decodes the lit-bit position.
- Learns the rotation direction, locks once the steps are consistent, counts full revolutions and flags illegal patterns or steps.
- Sits beside the LED driver as an on-chip checker; its outputs feed status LEDs and the verification bench.

---
 rtl/rotate_monitor.sv | 181 ++++++++++++++++++
 tb/tb_rotate_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rotate_monitor.sv
// rotate_monitor
// Receiving-end checker for an 8-bit one-hot rotating LED pattern.
//
// On each sample strobe the block classifies the pattern:
//   - a repeat of the previous sample
//   - a one-hot step left or right
//   - a non-adjacent one-hot jump
//   - zero or multi-hot
// From this it learns the rotation direction and locks after LOCK_STEPS
// consistent steps. It counts full revolutions while locked, and flags
// anything that breaks the lock.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   sample_en   one-cycle sample strobe
//   rotate_data observed 8-bit pattern
//   position    index of the lit bit in the last legal sample
//   pos_valid   position holds a decoded one-hot sample
//   direction   0 = left (index +1), 1 = right (index -1); valid while locked
//   locked      monitor is locked onto a consistent rotation
//   step_err    one-cycle pulse on an illegal pattern or step while locked
//   err_count   saturating count of step_err pulses
//   rev_count   full revolutions seen while locked (wrapping)
module rotate_monitor #(
  parameter int LOCK_STEPS = 2,
  parameter int REV_W      = 8,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [7:0]       rotate_data,
  output logic [2:0]       position,
  output logic             pos_valid,
  output logic             direction,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
  output logic [REV_W-1:0] rev_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_STEPS);

  state_t           state, state_n;
  logic [2:0]       step_cnt, step_cnt_n;
  logic [7:0]       prev_sample, prev_sample_n;
  logic [2:0]       position_n;
  logic             pos_valid_n;
  logic             direction_n;
  logic             step_err_n;
  logic [ERR_W-1:0] err_count_n;
  logic [REV_W-1:0] rev_count_n;

  logic [2:0]       idx;
  logic             one_hot;
  logic             is_same;
  logic             left_step;
  logic             right_step;

  // Pattern classification. The previous index is the stored position,
  // which always matches the previous sample whenever pos_valid is set.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (rotate_data[i]) idx = 3'(i);
    end
    one_hot    = (rotate_data != 8'd0) && ((rotate_data & (rotate_data - 8'd1)) == 8'd0);
    is_same    = (rotate_data == prev_sample);
    left_step  = one_hot && (idx == position + 3'd1);
    right_step = one_hot && (idx == position - 3'd1);
  end

  // Next-state and output logic. Everything holds unless a strobe carries
  // a sample that differs from the previous one.
  always_comb begin
    state_n       = state;
    step_cnt_n    = step_cnt;
    position_n    = position;
    pos_valid_n   = pos_valid;
    direction_n   = direction;
    step_err_n    = 1'b0;
    err_count_n   = err_count;
    rev_count_n   = rev_count;
    prev_sample_n = sample_en ? rotate_data : prev_sample;

    if (sample_en && !is_same) begin
      case (state)
        IDLE: begin
          if (one_hot) begin
            position_n  = idx;
            pos_valid_n = 1'b1;
            step_cnt_n  = 3'd0;
            state_n     = ACQUIRE;
          end
        end

        ACQUIRE: begin
          if (!one_hot) begin
            pos_valid_n = 1'b0;
            step_cnt_n  = 3'd0;
            state_n     = IDLE;
          end else if (left_step || right_step) begin
            // A count of zero means no candidate direction yet; a
            // reversal restarts the run in the new direction.
            if (step_cnt != 3'd0 && right_step == direction)
              step_cnt_n = step_cnt + 3'd1;
            else
              step_cnt_n = 3'd1;
            direction_n = right_step;
            position_n  = idx;
            if (step_cnt_n >= LOCK_CNT) state_n = LOCKED;
          end else begin
            position_n = idx;
            step_cnt_n = 3'd0;
          end
        end

        LOCKED: begin
          if ((left_step && !direction) || (right_step && direction)) begin
            position_n = idx;
            // The wrap step completes a revolution in either direction.
            if ((!direction && idx == 3'd0) || (direction && idx == 3'd7))
              rev_count_n = rev_count + 1'b1;
          end else begin
            step_err_n = 1'b1;
            if (err_count != '1) err_count_n = err_count + 1'b1;
            step_cnt_n = 3'd0;
            if (one_hot) begin
              position_n = idx;
              state_n    = ACQUIRE;
            end else begin
              pos_valid_n = 1'b0;
              state_n     = IDLE;
            end
          end
        end

        default: begin
          pos_valid_n = 1'b0;
          step_cnt_n  = 3'd0;
          state_n     = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset wins over a coincident strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      step_cnt    <= 3'd0;
      prev_sample <= 8'd0;
      position    <= 3'd0;
      pos_valid   <= 1'b0;
      direction   <= 1'b0;
      step_err    <= 1'b0;
      err_count   <= '0;
      rev_count   <= '0;
    end else begin
      state       <= state_n;
      step_cnt    <= step_cnt_n;
      prev_sample <= prev_sample_n;
      position    <= position_n;
      pos_valid   <= pos_valid_n;
      direction   <= direction_n;
      step_err    <= step_err_n;
      err_count   <= err_count_n;
      rev_count   <= rev_count_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_rotate_monitor.sv
// tb_rotate_monitor
// Directed and randomized bench for rotate_monitor. A behavioural model
// tracks what the monitor should report in terms of "tracking", "locked",
// a run length of same-direction steps and modular index arithmetic.
module tb_rotate_monitor;

  localparam int LOCK_STEPS = 2;
  localparam int REV_W      = 8;
  localparam int ERR_W      = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sample_en = 1'b0;
  logic [7:0]       rotate_data = 8'd0;
  logic [2:0]       position;
  logic             pos_valid;
  logic             direction;
  logic             locked;
  logic             step_err;
  logic [ERR_W-1:0] err_count;
  logic [REV_W-1:0] rev_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_prev, m_pos, m_dir, m_run, m_rev, m_err;
  bit   m_tracking, m_locked, m_pulse;

  always #5 clk = ~clk;

  rotate_monitor #(
    .LOCK_STEPS(LOCK_STEPS),
    .REV_W(REV_W),
    .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_en(sample_en),
    .rotate_data(rotate_data),
    .position(position),
    .pos_valid(pos_valid),
    .direction(direction),
    .locked(locked),
    .step_err(step_err),
    .err_count(err_count),
    .rev_count(rev_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural update for one clock edge with the given inputs.
  task automatic modelStep(input bit rst_n, input bit en, input int d);
    bit oh;
    int idx, want, new_dir;
    m_pulse = 1'b0;
    if (!rst_n) begin
      m_prev = 0; m_pos = 0; m_dir = 0; m_run = 0; m_rev = 0; m_err = 0;
      m_tracking = 1'b0; m_locked = 1'b0;
      return;
    end
    if (!en) return;
    if (d != m_prev) begin
      oh  = ($countones(d[7:0]) == 1);
      idx = oh ? $clog2(d) : 0;
      if (!m_tracking) begin
        if (oh) begin m_tracking = 1'b1; m_pos = idx; m_run = 0; end
      end else if (!m_locked) begin
        if (!oh) begin
          m_tracking = 1'b0; m_run = 0;
        end else if (idx == (m_pos + 1) % 8 || idx == (m_pos + 7) % 8) begin
          new_dir = (idx == (m_pos + 7) % 8) ? 1 : 0;
          m_run = (m_run > 0 && new_dir == m_dir) ? m_run + 1 : 1;
          m_dir = new_dir;
          m_pos = idx;
          if (m_run >= LOCK_STEPS) m_locked = 1'b1;
        end else begin
          m_pos = idx; m_run = 0;
        end
      end else begin
        want = m_dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
        if (oh && idx == want) begin
          if ((m_dir == 0 && idx == 0) || (m_dir == 1 && idx == 7))
            m_rev = (m_rev + 1) % (1 << REV_W);
          m_pos = idx;
        end else begin
          m_pulse = 1'b1;
          if (m_err < (1 << ERR_W) - 1) m_err++;
          m_locked = 1'b0;
          m_run = 0;
          if (oh) m_pos = idx;
          else m_tracking = 1'b0;
        end
      end
    end
    m_prev = d;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".position"},  32'(position),  32'(m_pos));
    check({tag, ".pos_valid"}, 32'(pos_valid), 32'(m_tracking));
    check({tag, ".locked"},    32'(locked),    32'(m_locked));
    check({tag, ".step_err"},  32'(step_err),  32'(m_pulse));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
    check({tag, ".rev_count"}, 32'(rev_count), 32'(m_rev));
    if (m_locked) check({tag, ".direction"}, 32'(direction), 32'(m_dir));
  endtask

  // Drive one clock cycle, advance the model, and compare just after the edge.
  task automatic applyStimulus(input string tag, input bit rst_n, input bit en, input logic [7:0] d);
    @(negedge clk);
    reset       = rst_n;
    sample_en   = en;
    rotate_data = d;
    @(posedge clk);
    modelStep(rst_n, en, int'(d));
    #1;
    checkOutput(tag);
  endtask

  task automatic sample(input string tag, input logic [7:0] d);
    applyStimulus(tag, 1'b1, 1'b1, d);
    applyStimulus({tag, ".gap"}, 1'b1, 1'b0, d);
  endtask

  initial begin
    logic [7:0] pat;
    int         r, guard;

    $display("[TB] reset with noisy inputs");
    for (int i = 0; i < 4; i++) applyStimulus("reset", 1'b0, i[0], 8'h5A);

    $display("[TB] acquire and lock left");
    sample("lock01", 8'h01);
    sample("lock02", 8'h02);
    sample("lock04", 8'h04);
    check("lock.locked_after_04", 32'(locked), 32'd1);
    sample("lock08", 8'h08);
    check("lock.position_3", 32'(position), 32'd3);

    $display("[TB] revolution and repeated samples");
    sample("rev10", 8'h10);
    sample("rev20", 8'h20);
    sample("rev40", 8'h40);
    sample("rev80", 8'h80);
    sample("rev01", 8'h01);
    check("rev.count_1", 32'(rev_count), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus("repeat01", 1'b1, 1'b1, 8'h01);

    $display("[TB] jump while locked, relock right");
    sample("j02", 8'h02);
    sample("j04", 8'h04);
    sample("j08", 8'h08);
    applyStimulus("jump20", 1'b1, 1'b1, 8'h20);
    check("jump.step_err", 32'(step_err), 32'd1);
    applyStimulus("jump.pulse_end", 1'b1, 1'b0, 8'h20);
    sample("r10", 8'h10);
    sample("r08", 8'h08);
    check("relock.direction_right", 32'(direction), 32'd1);

    $display("[TB] zero then multi-hot while locked");
    sample("z00", 8'h00);
    sample("m03", 8'h03);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 16; i++) begin
      sample("sat01", 8'h01);
      sample("sat02", 8'h02);
      sample("sat04", 8'h04);
      sample("sat00", 8'h00);
    end
    check("sat.err_count_F", 32'(err_count), 32'hF);

    $display("[TB] reset mid-revolution");
    pat = 8'h01;
    guard = 0;
    while (m_rev < 3 && guard < 100) begin
      sample("spin", pat);
      pat = {pat[6:0], pat[7]};
      guard++;
    end
    check("spin.rev_count_3", 32'(rev_count), 32'd3);
    applyStimulus("midreset", 1'b0, 1'b1, pat);
    sample("re01", 8'h01);
    sample("re02", 8'h02);
    sample("re04", 8'h04);
    check("relock.after_reset", 32'(locked), 32'd1);

    $display("[TB] randomized patterns");
    pat = 8'h01;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      pat = {pat[6:0], pat[7]};
      else if (r < 75) pat = {pat[0], pat[7:1]};
      else if (r < 85) ;
      else if (r < 92) pat = 8'(1 << $urandom_range(0, 7));
      else if (r < 95) pat = 8'h00;
      else             pat = 8'($urandom);
      if (pat == 8'h00 && r < 85) pat = 8'h01;
      applyStimulus("rand", 1'b1, ($urandom_range(0, 3) != 0), pat);
      if (pat == 8'h00 || $countones(pat) != 1) pat = 8'h01;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
